// File: rtl/sample_cdc_receiver_pkg.sv
// audio_cdc_pkg: shared constants and FSM state type for the sample CDC receiver
package audio_cdc_pkg;
   localparam int SAMPLE_WIDTH       = 12;
   localparam int DEFAULT_FIFO_DEPTH = 4;
   typedef enum logic [1:0] {
      RESYNC   = 2'd0,
      IDLE     = 2'd1,
      WAIT_LOW = 2'd2
   } cdc_state_e;
endpackage

// File: rtl/sample_cdc_receiver_sync_ff.sv
// sync_ff: multi-stage single-bit synchronizer with synchronous reset
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff_q;
   logic [STAGES-1:0] ff_d;
   // shift the asynchronous input through the chain
   always_comb ff_d = {ff_q[STAGES-2:0], d};
   // chain registers
   always_ff @(posedge clk) begin
      if (rst) ff_q <= '0;
      else     ff_q <= ff_d;
   end
   assign q = ff_q[STAGES-1];
endmodule

// File: rtl/sample_cdc_receiver.sv
// sample_cdc_receiver: 4-phase req/ack sample receiver with FIFO toward the DAC; CDC_UNDERRUN_CNT_EN adds underrun_cnt/underrun outputs
module sample_cdc_receiver
   import audio_cdc_pkg::*;
#(
   parameter int WIDTH       = SAMPLE_WIDTH,
   parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx_req,
   input  logic [WIDTH-1:0]            rx_data,
   output logic                        rx_ack,
   input  logic                        sample_req,
   output logic [WIDTH-1:0]            sample_out,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef CDC_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                 underrun_cnt,
   output logic                        underrun
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(SYNC_STAGES + 1);

   logic             req_s;
   cdc_state_e       state_q, state_d;
   logic             ack_q, ack_d;
   logic [CW-1:0]    warm_q, warm_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [WIDTH-1:0] out_q, out_d;
   logic             full, empty, wr_en, rd_en, warm;

   sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_req),
      .q   (req_s)
   );

   assign full  = level_q == LW'(FIFO_DEPTH);
   assign empty = level_q == '0;
   assign rd_en = sample_req && !empty;
   // the synchronizer is cleared by reset, so req_s only reflects rx_req again after SYNC_STAGES cycles
   assign warm  = warm_q == CW'(SYNC_STAGES);

   // handshake FSM: RESYNC waits for a real req low so a reset mid-handshake cannot re-capture
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      warm_d  = warm_q;
      wr_en   = 1'b0;
      case (state_q)
         RESYNC: begin
            ack_d  = 1'b0;
            warm_d = warm ? warm_q : warm_q + CW'(1);
            if (warm && !req_s) state_d = IDLE;
         end
         IDLE: begin
            if (req_s && !full) begin
               wr_en   = 1'b1;
               ack_d   = 1'b1;
               state_d = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = RESYNC;
         end
      endcase
   end

   // sample FIFO; an empty FIFO never bypasses a same-cycle write to the reader
   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(wr_en) - LW'(rd_en);
      out_d    = rd_en ? mem_q[rd_ptr_q] : out_q;
   end

   // state, FIFO and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RESYNC;
         ack_q    <= 1'b0;
         warm_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         mem_q    <= '{default: '0};
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         warm_q   <= warm_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         mem_q    <= mem_d;
         out_q    <= out_d;
      end
   end

   assign rx_ack     = ack_q;
   assign sample_out = out_q;
   assign fifo_level = level_q;

`ifdef CDC_UNDERRUN_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;
   logic        und_q, und_d;
   // saturating count of strobes that find the FIFO empty
   always_comb begin
      und_d  = sample_req && empty;
      ucnt_d = (und_d && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
   end
   // underrun registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ucnt_q <= '0;
         und_q  <= 1'b0;
      end else begin
         ucnt_q <= ucnt_d;
         und_q  <= und_d;
      end
   end
   assign underrun_cnt = ucnt_q;
   assign underrun     = und_q;
`endif
endmodule

// File: tb/tb_sample_cdc_receiver.sv
// tb_sample_cdc_receiver: randomized self-checking bench against a queue-based model of the receiver
module tb_sample_cdc_receiver;
   localparam int SS = 2;
   localparam int D  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_req = 1'b0;
   logic [11:0] rx_data = '0;
   logic        rx_ack;
   logic        sample_req = 1'b0;
   logic [11:0] sample_out;
   logic [2:0]  fifo_level;
`ifdef CDC_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
   logic        underrun;
`endif

   sample_cdc_receiver #(.WIDTH(12), .FIFO_DEPTH(D), .SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_req     (rx_req),
      .rx_data    (rx_data),
      .rx_ack     (rx_ack),
      .sample_req (sample_req),
      .sample_out (sample_out),
      .fifo_level (fifo_level)
`ifdef CDC_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt),
      .underrun     (underrun)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: req seen SS edges late (2 = not yet valid after reset),
   // one capture per req-high phase, no capture until req is seen low after reset
   logic [11:0] m_q [$];
   int          syncq [$];
   bit          blocked, got, m_und;
   logic [11:0] m_out;
   int          m_cnt, rs, n;

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         syncq.delete();
         for (int i = 0; i < SS; i++) syncq.push_back(2);
         blocked = 1'b1;
         got     = 1'b0;
         m_out   = '0;
         m_cnt   = 0;
         m_und   = 1'b0;
      end else begin
         rs = syncq.pop_front();
         syncq.push_back(int'(rx_req));
         n = m_q.size();
         m_und = sample_req && n == 0;
         if (m_und && m_cnt < 65535) m_cnt++;
         if (sample_req && n > 0) m_out = m_q.pop_front();
         if (rs == 0) begin
            blocked = 1'b0;
            got     = 1'b0;
         end else if (rs == 1 && !blocked && !got && n < D) begin
            m_q.push_back(rx_data);
            got = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ack", rx_ack, got);
         chk("out", sample_out, m_out);
         chk("lvl", fifo_level, m_q.size());
`ifdef CDC_UNDERRUN_CNT_EN
         chk("ucnt", underrun_cnt, m_cnt);
         chk("und", underrun, m_und);
`endif
      end
   end

   // consumer: explicit pulses first, otherwise random strobes when enabled
   int pulses_req = 0;
   int pulses_done = 0;
   bit cons_en = 1'b0;
   int cons_pct = 30;

   initial begin
      forever begin
         @(negedge clk);
         if (pulses_done != pulses_req) begin
            sample_req = 1'b1;
            pulses_done++;
         end else sample_req = cons_en && ($urandom_range(0, 99) < cons_pct);
      end
   end

   task automatic pulse();
      @(posedge clk);
      pulses_req++;
   endtask

   task automatic send(input logic [11:0] d, output int lat);
      int t;
      @(negedge clk);
      rx_data = d;
      rx_req  = 1'b1;
      lat     = 0;
      while (!rx_ack && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      chk("send_ack", rx_ack, 1'b1);
      rx_req = 1'b0;
      t = 0;
      while (rx_ack && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("send_rel", rx_ack, 1'b0);
   endtask

   task automatic drain();
      cons_en  = 1'b1;
      cons_pct = 50;
      for (int i = 0; i < 400 && m_q.size() != 0; i++) @(negedge clk);
      cons_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("drain_lvl", fifo_level, 0);
   endtask

   initial begin
      int lat, t;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_ack", rx_ack, 0);
      chk("rst_out", sample_out, 0);
      chk("rst_lvl", fifo_level, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      send(12'hA5C, lat);
      chk("ack_latency", lat, SS + 1);
      repeat (2) @(negedge clk);
      chk("single_lvl", fifo_level, 1);
      pulse();
      repeat (3) @(negedge clk);
      chk("single_out", sample_out, 12'hA5C);
      chk("single_lvl0", fifo_level, 0);

      for (int i = 1; i <= 4; i++) send(12'(i), lat);
      chk("bp_full", fifo_level, 4);
      @(negedge clk);
      rx_data = 12'd5;
      rx_req  = 1'b1;
      repeat (8) @(negedge clk);
      chk("bp_noack", rx_ack, 0);
      chk("bp_lvl", fifo_level, 4);
      pulse();
      t = 0;
      while (!rx_ack && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("bp_ack5", rx_ack, 1);
      chk("bp_out", sample_out, 1);
      chk("bp_lvl4", fifo_level, 4);
      rx_req = 1'b0;
      repeat (6) @(negedge clk);
      repeat (4) pulse();
      repeat (4) @(negedge clk);
      chk("bp_last", sample_out, 5);
      chk("bp_empty", fifo_level, 0);

      send(12'h123, lat);
      pulse();
      repeat (3) @(negedge clk);
      chk("ur_pre", sample_out, 12'h123);
      pulse();
      repeat (3) @(negedge clk);
      chk("ur_out", sample_out, 12'h123);
      chk("ur_lvl", fifo_level, 0);
`ifdef CDC_UNDERRUN_CNT_EN
      chk("ur_cnt", underrun_cnt, 1);
`endif

      send(12'h201, lat);
      send(12'h202, lat);
      @(negedge clk);
      rx_data = 12'h203;
      rx_req  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      pulses_req++;
      @(negedge clk);
      @(negedge clk);
      chk("sim_lvl", fifo_level, 2);
      chk("sim_ack", rx_ack, 1);
      chk("sim_out", sample_out, 12'h201);
      rx_req = 1'b0;
      repeat (5) @(negedge clk);
      pulse();
      repeat (3) @(negedge clk);
      chk("sim_ord2", sample_out, 12'h202);
      pulse();
      repeat (3) @(negedge clk);
      chk("sim_ord3", sample_out, 12'h203);

      @(negedge clk);
      rx_data = 12'h3AA;
      rx_req  = 1'b1;
      t = 0;
      while (!rx_ack && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("mid_ack", rx_ack, 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_ack0", rx_ack, 0);
      chk("mid_lvl0", fifo_level, 0);
      rx_req = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_lvl_low", fifo_level, 0);
      send(12'h3BB, lat);
      pulse();
      repeat (3) @(negedge clk);
      chk("mid_out", sample_out, 12'h3BB);

      cons_en  = 1'b1;
      cons_pct = 40;
      for (int i = 1; i <= 10; i++) send(12'(i), lat);
      drain();
      chk("wrap_last", sample_out, 12'h00A);

      for (int i = 0; i < 150; i++) begin
         cons_en  = 1'b1;
         cons_pct = $urandom_range(5, 90);
         send(12'($urandom), lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
